cci_mpf_vtp_csr_ctrl: RTL and testbench
=======================================

CCI_MPF_VTP_CSR_CTRL -- requirements
Module: cci_mpf_vtp_csr_ctrl

Interface
REQ-001 SHALL have parameter CSR_BASE_ADDR, default 0, byte MMIO address of this feature's DFH (8-byte aligned).
REQ-002 SHALL have parameter DFH_NEXT_OFFSET, default 0, 24-bit next-feature byte offset placed in DFH.
REQ-003 SHALL have ports: clk input 1 (sole clock); reset input 1 (asynchronous, active-high).
REQ-004 SHALL have ports: mmio_wr_valid input 1; mmio_wr_addr input 16 (byte addr); mmio_wr_data input 64.
REQ-005 SHALL have ports: mmio_rd_valid input 1; mmio_rd_addr input 16; mmio_rd_tid input 9.
REQ-006 SHALL have ports: mmio_rsp_valid output 1; mmio_rsp_tid output 9; mmio_rsp_data output 64.
REQ-007 SHALL have ports: csr_mode output t_cci_mpf_vtp_csr_mode; csr_pt_base output 64 (page-table PA).
REQ-008 SHALL have ports: inval_req output 1; inval_va output 64; inval_all output 1; inval_ack input 1.
REQ-009 SHALL have ports: stat_hit input 1; stat_miss input 1 (one-cycle event strobes from VTP).

Function
REQ-010 SHALL decode word offsets from CSR_BASE_ADDR: 0x00 DFH (RO), 0x08 ID_L (RO), 0x10 ID_H (RO), 0x18 MODE (RW), 0x20 PT_BASE (RW), 0x28 INVAL_VA (WO), 0x30 STATUS (RO), 0x38 HIT_CNT (RO), 0x40 MISS_CNT (RO).
REQ-011 SHALL ignore writes outside the decoded range and to RO offsets; reads of undecoded offsets inside the range return 0; reads outside the range produce no response.
REQ-012 SHALL return read data exactly 2 cycles after mmio_rd_valid, with mmio_rsp_tid equal to captured mmio_rd_tid, mmio_rsp_valid high for 1 cycle.
REQ-013 SHALL accept one read per cycle, fully pipelined.
REQ-014 SHALL, on simultaneous read and write to the same offset, return the pre-write value.
REQ-015 SHALL update csr_mode.enabled from MODE write bit0, visible the cycle after the write.
REQ-016 SHALL treat MODE write bit1=1 as a full invalidation request; csr_mode.inval_translation_cache SHALL pulse high exactly one cycle and never read back as 1.
REQ-017 SHALL treat any INVAL_VA write as a single-page invalidation request for that VA.
REQ-018 SHALL run invalidation FSM IDLE -> REQ (inval_req=1, inval_va/inval_all stable) -> IDLE on inval_ack while in REQ.
REQ-019 SHALL hold one additional request in a one-deep queue while in REQ; on ack, queued request issues the next cycle.
REQ-020 SHALL, on a new request with REQ active and queue full, drop it and set sticky STATUS bit0 (overflow), cleared only by reset.
REQ-021 SHALL report STATUS bit1 = inval_req, bit2 = queue occupied.
REQ-022 SHALL ignore inval_ack while IDLE.

Reset
REQ-023 SHALL, on asserted reset, immediately clear: mmio_rsp_valid, csr_mode, csr_pt_base, inval_req, inval_va, inval_all, queue, STATUS, counters; FSM to IDLE.
REQ-024 SHALL drop any in-flight read response and pending invalidation when reset asserts mid-operation.

Configuration
REQ-025 SHALL, with MPF_VTP_CSR_STATS_EN defined, implement 48-bit HIT_CNT/MISS_CNT incrementing on stat_hit/stat_miss, saturating at all-ones, readable zero-extended.
REQ-026 SHALL, without MPF_VTP_CSR_STATS_EN, omit the counters; HIT_CNT/MISS_CNT read 0; stat_* inputs unused.

Structure
REQ-027 SHALL place CSR offset constants, t_cci_mpf_vtp_csr_mode, and the VTP feature UUID in cci_mpf_csrs_pkg.
REQ-028 SHALL implement invalidation FSM plus queue as sub-module cci_mpf_vtp_inval_fsm.

Verification
REQ-029 Read DFH at CSR_BASE_ADDR, tid 0x155 -> response after 2 cycles, tid 0x155, DFH next field = DFH_NEXT_OFFSET.
REQ-030 Write MODE=0x3 -> enabled=1 next cycle, inval_translation_cache 1-cycle pulse, inval_req=1 with inval_all=1; ack -> idle; MODE readback 0x1.
REQ-031 Three INVAL_VA writes (0x1000, 0x2000, 0x3000) with ack held low -> 0x1000 issued, 0x2000 queued, 0x3000 dropped, STATUS=0x7; ack twice -> 0x2000 issued then idle, STATUS=0x1.
REQ-032 Write PT_BASE=0xDEAD_B000 and read it same cycle -> response returns 0; next read returns 0xDEAD_B000.
REQ-033 With STATS_EN, 5 stat_hit and 3 stat_miss pulses -> HIT_CNT=5, MISS_CNT=3; without it both read 0.
REQ-034 Assert reset with read in flight and inval_req high -> no response emitted, inval_req=0, all CSRs read 0/initial after release.

Source files
------------

// File: rtl/cci_mpf_csrs_pkg.sv
// Shared CSR definitions for the MPF VTP control block: register offsets,
// the mode structure driven to the translation pipeline, the VTP feature
// UUID, the invalidation FSM state type and the DFH builder.
package cci_mpf_csrs_pkg;

  // Byte offsets of each CSR relative to the feature base address.
  localparam logic [6:0] CCI_MPF_VTP_CSR_DFH      = 7'h00;
  localparam logic [6:0] CCI_MPF_VTP_CSR_ID_L     = 7'h08;
  localparam logic [6:0] CCI_MPF_VTP_CSR_ID_H     = 7'h10;
  localparam logic [6:0] CCI_MPF_VTP_CSR_MODE     = 7'h18;
  localparam logic [6:0] CCI_MPF_VTP_CSR_PT_BASE  = 7'h20;
  localparam logic [6:0] CCI_MPF_VTP_CSR_INVAL_VA = 7'h28;
  localparam logic [6:0] CCI_MPF_VTP_CSR_STATUS   = 7'h30;
  localparam logic [6:0] CCI_MPF_VTP_CSR_HIT_CNT  = 7'h38;
  localparam logic [6:0] CCI_MPF_VTP_CSR_MISS_CNT = 7'h40;

  // VTP feature UUID c8a2982f-ff96-42bf-a705-45727f501901.
  localparam logic [127:0] CCI_MPF_VTP_UUID = 128'hc8a2982f_ff96_42bf_a705_45727f501901;

  // Mode bits seen by the VTP pipeline.
  typedef struct packed {
    logic inval_translation_cache;
    logic enabled;
  } t_cci_mpf_vtp_csr_mode;

  // Invalidation handshake states.
  typedef enum logic [0:0] {
    INVAL_IDLE = 1'b0,
    INVAL_REQ  = 1'b1
  } t_inval_state;

  // Private-feature DFH: type 3, not end-of-list, next offset in [39:16].
  function automatic logic [63:0] vtp_dfh(input logic [23:0] next_offset);
    return {4'h3, 19'h0, 1'b0, next_offset, 4'h0, 12'h000};
  endfunction

endpackage

// File: rtl/cci_mpf_vtp_inval_fsm.sv
// Invalidation request sequencer. Presents one request at a time on
// inval_req/inval_va/inval_all until acknowledged, holds one further request
// in a single-entry queue, and flags a sticky overflow when a request arrives
// with both the active slot and the queue occupied.
module cci_mpf_vtp_inval_fsm
  import cci_mpf_csrs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        new_req,
  input  logic [63:0] new_va,
  input  logic        new_all,
  input  logic        inval_ack,
  output logic        inval_req,
  output logic [63:0] inval_va,
  output logic        inval_all,
  output logic        queue_valid,
  output logic        overflow
);

  t_inval_state state;
  logic [63:0]  q_va;
  logic         q_all;

  // Request/ack state machine with one-deep queue and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INVAL_IDLE;
      inval_req   <= 1'b0;
      inval_va    <= 64'd0;
      inval_all   <= 1'b0;
      queue_valid <= 1'b0;
      q_va        <= 64'd0;
      q_all       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        INVAL_IDLE: begin
          // Ack is meaningless here and deliberately ignored.
          if (new_req) begin
            state     <= INVAL_REQ;
            inval_req <= 1'b1;
            inval_va  <= new_va;
            inval_all <= new_all;
          end
        end
        INVAL_REQ: begin
          if (inval_ack) begin
            if (queue_valid) begin
              // Queued request becomes active; a same-cycle arrival refills the queue.
              inval_va    <= q_va;
              inval_all   <= q_all;
              queue_valid <= new_req;
              if (new_req) begin
                q_va  <= new_va;
                q_all <= new_all;
              end
            end else if (new_req) begin
              inval_va  <= new_va;
              inval_all <= new_all;
            end else begin
              state     <= INVAL_IDLE;
              inval_req <= 1'b0;
            end
          end else if (new_req) begin
            if (queue_valid) begin
              overflow <= 1'b1;
            end else begin
              queue_valid <= 1'b1;
              q_va        <= new_va;
              q_all       <= new_all;
            end
          end
        end
        default: begin
          state     <= INVAL_IDLE;
          inval_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cci_mpf_vtp_csr_ctrl.sv
// MMIO CSR block for the MPF VTP feature. Decodes a 0x80-byte window at
// CSR_BASE_ADDR (8-byte aligned registers; misaligned or unassigned words
// inside the window read 0 and ignore writes; accesses outside the window
// are ignored and reads there get no response). Reads return two cycles
// after the request. Optional hit/miss statistics counters are built when
// the macro MPF_VTP_CSR_STATS_EN is defined.
module cci_mpf_vtp_csr_ctrl
  import cci_mpf_csrs_pkg::*;
#(
  parameter int CSR_BASE_ADDR   = 0,
  parameter int DFH_NEXT_OFFSET = 0
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mmio_wr_valid,
  input  logic [15:0]           mmio_wr_addr,
  input  logic [63:0]           mmio_wr_data,
  input  logic                  mmio_rd_valid,
  input  logic [15:0]           mmio_rd_addr,
  input  logic [8:0]            mmio_rd_tid,
  output logic                  mmio_rsp_valid,
  output logic [8:0]            mmio_rsp_tid,
  output logic [63:0]           mmio_rsp_data,
  output t_cci_mpf_vtp_csr_mode csr_mode,
  output logic [63:0]           csr_pt_base,
  output logic                  inval_req,
  output logic [63:0]           inval_va,
  output logic                  inval_all,
  input  logic                  inval_ack,
  input  logic                  stat_hit,
  input  logic                  stat_miss
);

  localparam logic [16:0] BASE = {1'b0, 16'(CSR_BASE_ADDR)};
  localparam logic [63:0] DFH  = vtp_dfh(24'(DFH_NEXT_OFFSET));

  logic [16:0] wr_diff;
  logic [16:0] rd_diff;
  logic        wr_sel;
  logic        rd_sel;
  logic        wr_mode;
  logic        wr_pt;
  logic        wr_inval;
  logic        new_req;
  logic        new_all;
  logic [63:0] new_va;
  logic        queue_valid;
  logic        overflow;
  logic [63:0] status;
  logic [63:0] rd_data;
  logic [47:0] hit_cnt;
  logic [47:0] miss_cnt;

  logic        s1_valid;
  logic [8:0]  s1_tid;
  logic [63:0] s1_data;

  // A borrow in bit 16 means the address lies below the base.
  assign wr_diff = {1'b0, mmio_wr_addr} - BASE;
  assign rd_diff = {1'b0, mmio_rd_addr} - BASE;
  assign wr_sel  = mmio_wr_valid & ~wr_diff[16] & (wr_diff[15:7] == 9'd0);
  assign rd_sel  = mmio_rd_valid & ~rd_diff[16] & (rd_diff[15:7] == 9'd0);

  assign wr_mode  = wr_sel & (wr_diff[6:0] == CCI_MPF_VTP_CSR_MODE);
  assign wr_pt    = wr_sel & (wr_diff[6:0] == CCI_MPF_VTP_CSR_PT_BASE);
  assign wr_inval = wr_sel & (wr_diff[6:0] == CCI_MPF_VTP_CSR_INVAL_VA);

  // A MODE write with bit1 requests a full flush; INVAL_VA requests one page.
  assign new_all = wr_mode & mmio_wr_data[1];
  assign new_req = new_all | wr_inval;
  assign new_va  = wr_inval ? mmio_wr_data : 64'd0;

  assign status = {61'd0, queue_valid, inval_req, overflow};

  // Mode and page-table base registers; the flush bit is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_mode    <= '0;
      csr_pt_base <= 64'd0;
    end else begin
      csr_mode.inval_translation_cache <= new_all;
      if (wr_mode) begin
        csr_mode.enabled <= mmio_wr_data[0];
      end
      if (wr_pt) begin
        csr_pt_base <= mmio_wr_data;
      end
    end
  end

  cci_mpf_vtp_inval_fsm u_inval_fsm (
    .clk         (clk),
    .reset       (reset),
    .new_req     (new_req),
    .new_va      (new_va),
    .new_all     (new_all),
    .inval_ack   (inval_ack),
    .inval_req   (inval_req),
    .inval_va    (inval_va),
    .inval_all   (inval_all),
    .queue_valid (queue_valid),
    .overflow    (overflow)
  );

`ifdef MPF_VTP_CSR_STATS_EN
  // Saturating translation hit/miss event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= 48'd0;
      miss_cnt <= 48'd0;
    end else begin
      if (stat_hit && (hit_cnt != {48{1'b1}})) begin
        hit_cnt <= hit_cnt + 48'd1;
      end
      if (stat_miss && (miss_cnt != {48{1'b1}})) begin
        miss_cnt <= miss_cnt + 48'd1;
      end
    end
  end
`else
  logic unused_stat;
  assign unused_stat = stat_hit ^ stat_miss;
  assign hit_cnt     = 48'd0;
  assign miss_cnt    = 48'd0;
`endif

  // Read data select from current register state (pre-write on collisions).
  always_comb begin
    rd_data = 64'd0;
    case (rd_diff[6:0])
      CCI_MPF_VTP_CSR_DFH:      rd_data = DFH;
      CCI_MPF_VTP_CSR_ID_L:     rd_data = CCI_MPF_VTP_UUID[63:0];
      CCI_MPF_VTP_CSR_ID_H:     rd_data = CCI_MPF_VTP_UUID[127:64];
      CCI_MPF_VTP_CSR_MODE:     rd_data = {63'd0, csr_mode.enabled};
      CCI_MPF_VTP_CSR_PT_BASE:  rd_data = csr_pt_base;
      CCI_MPF_VTP_CSR_STATUS:   rd_data = status;
      CCI_MPF_VTP_CSR_HIT_CNT:  rd_data = {16'd0, hit_cnt};
      CCI_MPF_VTP_CSR_MISS_CNT: rd_data = {16'd0, miss_cnt};
      default:                  rd_data = 64'd0;
    endcase
  end

  // Two-stage read response pipeline, one new read accepted every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_tid         <= 9'd0;
      s1_data        <= 64'd0;
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_tid   <= 9'd0;
      mmio_rsp_data  <= 64'd0;
    end else begin
      s1_valid       <= rd_sel;
      s1_tid         <= mmio_rd_tid;
      s1_data        <= rd_data;
      mmio_rsp_valid <= s1_valid;
      mmio_rsp_tid   <= s1_tid;
      mmio_rsp_data  <= s1_data;
    end
  end

endmodule

// File: tb/tb_cci_mpf_vtp_csr_ctrl.sv
// Scoreboard bench for cci_mpf_vtp_csr_ctrl: reads push the expected
// {tid, data, arrival cycle} into a queue; a negedge monitor pops and
// compares every response. Side-band outputs are checked directly.
module tb_cci_mpf_vtp_csr_ctrl;
  import cci_mpf_csrs_pkg::*;

  localparam logic [15:0] BASE     = 16'h0100;
  localparam logic [23:0] NEXT_OFF = 24'hABCDE0;
  localparam logic [63:0] EXP_DFH  = 64'h3000_00AB_CDE0_0000;
  localparam logic [63:0] EXP_IDL  = 64'ha705_4572_7f50_1901;
  localparam logic [63:0] EXP_IDH  = 64'hc8a2_982f_ff96_42bf;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mmio_wr_valid;
  logic [15:0]           mmio_wr_addr;
  logic [63:0]           mmio_wr_data;
  logic                  mmio_rd_valid;
  logic [15:0]           mmio_rd_addr;
  logic [8:0]            mmio_rd_tid;
  logic                  mmio_rsp_valid;
  logic [8:0]            mmio_rsp_tid;
  logic [63:0]           mmio_rsp_data;
  t_cci_mpf_vtp_csr_mode csr_mode;
  logic [63:0]           csr_pt_base;
  logic                  inval_req;
  logic [63:0]           inval_va;
  logic                  inval_all;
  logic                  inval_ack;
  logic                  stat_hit;
  logic                  stat_miss;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  cci_mpf_vtp_csr_ctrl #(
    .CSR_BASE_ADDR   (int'(BASE)),
    .DFH_NEXT_OFFSET (int'(NEXT_OFF))
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mmio_wr_valid  (mmio_wr_valid),
    .mmio_wr_addr   (mmio_wr_addr),
    .mmio_wr_data   (mmio_wr_data),
    .mmio_rd_valid  (mmio_rd_valid),
    .mmio_rd_addr   (mmio_rd_addr),
    .mmio_rd_tid    (mmio_rd_tid),
    .mmio_rsp_valid (mmio_rsp_valid),
    .mmio_rsp_tid   (mmio_rsp_tid),
    .mmio_rsp_data  (mmio_rsp_data),
    .csr_mode       (csr_mode),
    .csr_pt_base    (csr_pt_base),
    .inval_req      (inval_req),
    .inval_va       (inval_va),
    .inval_all      (inval_all),
    .inval_ack      (inval_ack),
    .stat_hit       (stat_hit),
    .stat_miss      (stat_miss)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every response must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mmio_rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp: got tid=0x%0h data=0x%0h, required no response", mmio_rsp_tid, mmio_rsp_data);
        end else begin
          e = exp_q.pop_front();
          if (mmio_rsp_tid !== e.tid || mmio_rsp_data !== e.data || cyc != e.cyc) begin
            failures++;
            $display("FAIL rsp: got tid=0x%0h data=0x%0h cyc=%0d, required tid=0x%0h data=0x%0h cyc=%0d",
                     mmio_rsp_tid, mmio_rsp_data, cyc, e.tid, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [63:0] data);
    mmio_wr_valid = 1'b1;
    mmio_wr_addr  = addr;
    mmio_wr_data  = data;
    step();
    mmio_wr_valid = 1'b0;
  endtask

  // Issue a read; when a response is expected, queue it for two cycles later.
  task automatic rd(input logic [15:0] addr, input logic [8:0] tid,
                    input logic [63:0] expv, input bit want_rsp);
    exp_t e;
    mmio_rd_valid = 1'b1;
    mmio_rd_addr  = addr;
    mmio_rd_tid   = tid;
    if (want_rsp) begin
      e.tid  = tid;
      e.data = expv;
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
    end
    step();
    mmio_rd_valid = 1'b0;
  endtask

  task automatic ack_once();
    inval_ack = 1'b1;
    step();
    inval_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_hit;
    logic [63:0] exp_miss;
    reset = 1'b1;
    mmio_wr_valid = 1'b0; mmio_wr_addr = 16'h0000; mmio_wr_data = 64'd0;
    mmio_rd_valid = 1'b0; mmio_rd_addr = 16'h0000; mmio_rd_tid = 9'd0;
    inval_ack = 1'b0; stat_hit = 1'b0; stat_miss = 1'b0;
    step(); step();
    check("reset_rsp_valid", {63'd0, mmio_rsp_valid}, 64'd0);
    check("reset_mode", {62'd0, csr_mode}, 64'd0);
    check("reset_pt_base", csr_pt_base, 64'd0);
    check("reset_inval", {62'd0, inval_req, inval_all}, 64'd0);
    check("reset_inval_va", inval_va, 64'd0);
    reset = 1'b0;
    step();

    // Identity registers, pipelined back-to-back.
    rd(BASE,          9'h155, EXP_DFH, 1'b1);
    rd(BASE + 16'h08, 9'h001, EXP_IDL, 1'b1);
    rd(BASE + 16'h10, 9'h002, EXP_IDH, 1'b1);
    // Outside the window: no response. Inside but undecoded/misaligned: 0.
    rd(BASE - 16'h08, 9'h003, 64'd0, 1'b0);
    rd(BASE + 16'h80, 9'h004, 64'd0, 1'b0);
    rd(BASE + 16'h48, 9'h005, 64'd0, 1'b1);
    rd(BASE + 16'h1C, 9'h006, 64'd0, 1'b1);
    // Writes to RO or out-of-window addresses change nothing.
    wr(BASE,          64'hFFFF_FFFF_FFFF_FFFF);
    wr(BASE + 16'h08, 64'h1234);
    wr(BASE + 16'h120, 64'hBAD0);
    rd(BASE,          9'h007, EXP_DFH, 1'b1);
    rd(BASE + 16'h08, 9'h008, EXP_IDL, 1'b1);
    check("ro_pt_base", csr_pt_base, 64'd0);

    // MODE = 3: enable plus full flush.
    wr(BASE + 16'h18, 64'h3);
    check("mode_enabled", {63'd0, csr_mode.enabled}, 64'd1);
    check("mode_flush_pulse", {63'd0, csr_mode.inval_translation_cache}, 64'd1);
    check("flush_req", {62'd0, inval_req, inval_all}, 64'h3);
    step();
    check("mode_flush_pulse_end", {63'd0, csr_mode.inval_translation_cache}, 64'd0);
    check("flush_req_hold", {62'd0, inval_req, inval_all}, 64'h3);
    rd(BASE + 16'h18, 9'h010, 64'h1, 1'b1);
    ack_once();
    check("flush_done", {63'd0, inval_req}, 64'd0);
    ack_once();
    check("ack_idle_ignored", {63'd0, inval_req}, 64'd0);
    rd(BASE + 16'h30, 9'h011, 64'h0, 1'b1);

    // Three page invalidations with ack low: issue, queue, drop.
    wr(BASE + 16'h28, 64'h1000);
    check("va1_req", {62'd0, inval_req, inval_all}, 64'h2);
    check("va1_addr", inval_va, 64'h1000);
    wr(BASE + 16'h28, 64'h2000);
    wr(BASE + 16'h28, 64'h3000);
    rd(BASE + 16'h30, 9'h012, 64'h7, 1'b1);
    check("va1_stable", inval_va, 64'h1000);
    ack_once();
    check("va2_req", {63'd0, inval_req}, 64'd1);
    check("va2_addr", inval_va, 64'h2000);
    rd(BASE + 16'h30, 9'h013, 64'h3, 1'b1);
    ack_once();
    check("va2_done", {63'd0, inval_req}, 64'd0);
    rd(BASE + 16'h30, 9'h014, 64'h1, 1'b1);

    // Same-cycle write/read of PT_BASE returns the old value.
    mmio_wr_valid = 1'b1; mmio_wr_addr = BASE + 16'h20; mmio_wr_data = 64'hDEAD_B000;
    rd(BASE + 16'h20, 9'h020, 64'h0, 1'b1);
    mmio_wr_valid = 1'b0;
    check("pt_base_out", csr_pt_base, 64'hDEAD_B000);
    rd(BASE + 16'h20, 9'h021, 64'hDEAD_B000, 1'b1);

    // Statistics: 5 hits, 3 misses.
    for (int i = 0; i < 5; i++) begin
      stat_hit  = 1'b1;
      stat_miss = (i < 3) ? 1'b1 : 1'b0;
      step();
    end
    stat_hit = 1'b0; stat_miss = 1'b0;
`ifdef MPF_VTP_CSR_STATS_EN
    exp_hit  = 64'd5;
    exp_miss = 64'd3;
`else
    exp_hit  = 64'd0;
    exp_miss = 64'd0;
`endif
    rd(BASE + 16'h38, 9'h030, exp_hit, 1'b1);
    rd(BASE + 16'h40, 9'h031, exp_miss, 1'b1);
    step(); step(); step();

    // Reset with a read in flight and an invalidation pending.
    wr(BASE + 16'h28, 64'h4000);
    check("pre_reset_req", {63'd0, inval_req}, 64'd1);
    rd(BASE + 16'h18, 9'h040, 64'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_reset_req", {62'd0, inval_req, inval_all}, 64'd0);
    check("mid_reset_rsp", {63'd0, mmio_rsp_valid}, 64'd0);
    check("mid_reset_mode", {62'd0, csr_mode}, 64'd0);
    step(); step();
    reset = 1'b0;
    step(); step();
    rd(BASE + 16'h18, 9'h050, 64'd0, 1'b1);
    rd(BASE + 16'h20, 9'h051, 64'd0, 1'b1);
    rd(BASE + 16'h30, 9'h052, 64'd0, 1'b1);
    rd(BASE + 16'h38, 9'h053, 64'd0, 1'b1);
    rd(BASE + 16'h40, 9'h054, 64'd0, 1'b1);
    rd(BASE,          9'h055, EXP_DFH, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
